// File: rtl/lab3_mem_line_serializer.sv
// Line-to-word memory adapter: splits one cache-line request into p_words
// pipelined 32-bit word requests and gathers in-order word responses into a line.
module lab3_mem_line_serializer #(
    parameter int p_words = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  linereq_val,
    output logic                  linereq_rdy,
    input  logic [3:0]            linereq_type,
    input  logic [31:0]           linereq_addr,
    input  logic [32*p_words-1:0] linereq_data,

    output logic                  lineresp_val,
    input  logic                  lineresp_rdy,
    output logic [3:0]            lineresp_type,
    output logic [32*p_words-1:0] lineresp_data,

    output logic                  wordreq_val,
    input  logic                  wordreq_rdy,
    output logic [3:0]            wordreq_type,
    output logic [31:0]           wordreq_addr,
    output logic [31:0]           wordreq_data,

    input  logic                  wordresp_val,
    output logic                  wordresp_rdy,
    input  logic [3:0]            wordresp_type,
    input  logic [31:0]           wordresp_data
);

    localparam int L   = 32 * p_words;
    localparam int CW  = $clog2(p_words) + 1;
    localparam int OFF = $clog2(4 * p_words);
    localparam logic [31:0]   ALIGN_MASK = ~((32'd1 << OFF) - 32'd1);
    localparam logic [CW-1:0] LAST       = CW'(p_words);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] req_cnt_q, req_cnt_d;
    logic [CW-1:0] resp_cnt_q, resp_cnt_d;
    logic [3:0]    type_q, type_d;
    logic [31:0]   addr_q, addr_d;
    logic [L-1:0]  line_q, line_d;
    logic [L-1:0]  gather_q, gather_d;

    logic linereq_fire, lineresp_fire, wordreq_fire, wordresp_fire;
    logic unused_wordresp_type;

    always_comb unused_wordresp_type = ^wordresp_type;

    always_comb begin
        linereq_fire  = linereq_val  && linereq_rdy;
        lineresp_fire = lineresp_val && lineresp_rdy;
        wordreq_fire  = wordreq_val  && wordreq_rdy;
        wordresp_fire = wordresp_val && wordresp_rdy;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
            type_q     <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            gather_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_cnt_q  <= req_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            gather_q   <= gather_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_cnt_d  = req_cnt_q;
        resp_cnt_d = resp_cnt_q;
        type_d     = type_q;
        addr_d     = addr_q;
        line_d     = line_q;
        gather_d   = gather_q;
        case (state_q)
            IDLE: begin
                if (linereq_fire) begin
                    type_d     = linereq_type;
                    addr_d     = linereq_addr & ALIGN_MASK;
                    line_d     = linereq_data;
                    req_cnt_d  = '0;
                    resp_cnt_d = '0;
                    gather_d   = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (wordreq_fire) begin
                    req_cnt_d = req_cnt_q + CW'(1);
                end
                if (wordresp_fire) begin
                    resp_cnt_d = resp_cnt_q + CW'(1);
                    for (int unsigned i = 0; i < p_words; i++) begin
                        if (type_q == 4'd0 && resp_cnt_q == CW'(i)) begin
                            gather_d[32*i +: 32] = wordresp_data;
                        end
                    end
                end
                // Leave BUSY one edge after the final response has been counted.
                if (resp_cnt_q == LAST) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (lineresp_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        linereq_rdy   = 1'b0;
        lineresp_val  = 1'b0;
        lineresp_type = '0;
        lineresp_data = '0;
        wordreq_val   = 1'b0;
        wordreq_type  = '0;
        wordreq_addr  = '0;
        wordreq_data  = '0;
        wordresp_rdy  = 1'b0;
        case (state_q)
            IDLE: linereq_rdy = reset;
            BUSY: begin
                wordreq_val  = (req_cnt_q < LAST);
                wordreq_type = type_q;
                wordreq_addr = addr_q + (32'(req_cnt_q) << 2);
                for (int unsigned i = 0; i < p_words; i++) begin
                    if (type_q != 4'd0 && req_cnt_q == CW'(i)) begin
                        wordreq_data = line_q[32*i +: 32];
                    end
                end
                wordresp_rdy = (resp_cnt_q < LAST);
            end
            RESP: begin
                lineresp_val  = 1'b1;
                lineresp_type = type_q;
                lineresp_data = gather_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lab3_mem_line_serializer.sv
// Scoreboard bench for lab3_mem_line_serializer: a line-level reference model
// predicts word traffic and line responses; a monitor compares them as they occur.
module tb_lab3_mem_line_serializer;

    localparam int P = 4;
    localparam int L = 32 * P;

    logic          clk;
    logic          reset;
    logic          linereq_val, linereq_rdy;
    logic [3:0]    linereq_type;
    logic [31:0]   linereq_addr;
    logic [L-1:0]  linereq_data;
    logic          lineresp_val, lineresp_rdy;
    logic [3:0]    lineresp_type;
    logic [L-1:0]  lineresp_data;
    logic          wordreq_val, wordreq_rdy;
    logic [3:0]    wordreq_type;
    logic [31:0]   wordreq_addr, wordreq_data;
    logic          wordresp_val, wordresp_rdy;
    logic [3:0]    wordresp_type;
    logic [31:0]   wordresp_data;

    lab3_mem_line_serializer #(.p_words(P)) dut (
        .clk(clk), .reset(reset),
        .linereq_val(linereq_val), .linereq_rdy(linereq_rdy),
        .linereq_type(linereq_type), .linereq_addr(linereq_addr), .linereq_data(linereq_data),
        .lineresp_val(lineresp_val), .lineresp_rdy(lineresp_rdy),
        .lineresp_type(lineresp_type), .lineresp_data(lineresp_data),
        .wordreq_val(wordreq_val), .wordreq_rdy(wordreq_rdy),
        .wordreq_type(wordreq_type), .wordreq_addr(wordreq_addr), .wordreq_data(wordreq_data),
        .wordresp_val(wordresp_val), .wordresp_rdy(wordresp_rdy),
        .wordresp_type(wordresp_type), .wordresp_data(wordresp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct { logic [3:0] t; logic [L-1:0] d; } line_t;
    typedef struct { logic [3:0] t; logic [31:0] a; logic [31:0] d; } word_t;
    typedef struct { logic [31:0] d; int due; } pend_t;

    line_t exp_line_q[$];
    word_t exp_word_q[$];
    pend_t pend_q[$];
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    int delay_mode = 1;
    bit rand_wrdy  = 1'b0;
    int stall_left = 0;
    int lat_expect = 0;
    int acc_edge   = 0;
    int words_this_line = 0;
    int word_total = 0;

    // Test memory plus response-side back-pressure.
    pend_t pd;
    int    dly;
    always @(negedge clk) begin
        if (!reset) begin
            pend_q.delete();
            wordreq_rdy   = 1'b0;
            wordresp_val  = 1'b0;
            wordresp_data = '0;
            lineresp_rdy  = 1'b0;
        end else begin
            wordreq_rdy = rand_wrdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wordreq_val && wordreq_rdy) begin
                dly = (delay_mode < 0) ? int'($urandom_range(0, 5)) : delay_mode;
                if (wordreq_type == 4'd0) begin
                    pd.d = mem.exists(wordreq_addr) ? mem[wordreq_addr] : 32'd0;
                end else begin
                    mem[wordreq_addr] = wordreq_data;
                    pd.d = 32'd0;
                end
                pd.due = cyc + dly;
                pend_q.push_back(pd);
            end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                wordresp_val  = 1'b1;
                wordresp_data = pend_q[0].d;
                if (wordresp_rdy) void'(pend_q.pop_front());
            end else begin
                wordresp_val  = 1'b0;
                wordresp_data = $urandom;
            end
            if (lineresp_val && stall_left > 0) begin
                lineresp_rdy = 1'b0;
                stall_left--;
            end else begin
                lineresp_rdy = 1'b1;
            end
        end
    end

    // Monitor: compares word traffic and line responses against the scoreboard.
    bit           prev_wstall = 0, prev_lstall = 0, prev_lval = 0;
    word_t        prev_w;
    line_t        prev_l;
    word_t        wexp;
    line_t        lexp;
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            prev_wstall = 0;
            prev_lstall = 0;
            prev_lval   = 0;
        end else begin
            if (prev_wstall) begin
                chk("wreq_hold_val",  wordreq_val,  1'b1);
                chk("wreq_hold_addr", wordreq_addr, prev_w.a);
                chk("wreq_hold_data", wordreq_data, prev_w.d);
                chk("wreq_hold_type", wordreq_type, prev_w.t);
            end
            if (wordreq_val && wordreq_rdy) begin
                words_this_line++;
                word_total++;
                chk("wreq_expected", 32'(exp_word_q.size() > 0), 32'd1);
                if (exp_word_q.size() > 0) begin
                    wexp = exp_word_q.pop_front();
                    chk("wreq_addr", wordreq_addr, wexp.a);
                    chk("wreq_data", wordreq_data, wexp.d);
                    chk("wreq_type", wordreq_type, wexp.t);
                end
            end
            prev_wstall = wordreq_val && !wordreq_rdy;
            prev_w.a = wordreq_addr;
            prev_w.d = wordreq_data;
            prev_w.t = wordreq_type;

            if (prev_lstall) begin
                chk("lresp_hold_val",  lineresp_val,  1'b1);
                chk("lresp_hold_type", lineresp_type, prev_l.t);
                chk("lresp_hold_data", lineresp_data, prev_l.d);
            end
            if (lineresp_val && !prev_lval && lat_expect != 0) begin
                chk("latency", (cyc - 1) - acc_edge, lat_expect);
            end
            if (lineresp_val && lineresp_rdy) begin
                chk("word_count", words_this_line, P);
                words_this_line = 0;
                chk("lresp_expected", 32'(exp_line_q.size() > 0), 32'd1);
                if (exp_line_q.size() > 0) begin
                    lexp = exp_line_q.pop_front();
                    chk("lresp_type", lineresp_type, lexp.t);
                    chk("lresp_data", lineresp_data, lexp.d);
                end
            end
            prev_lstall = lineresp_val && !lineresp_rdy;
            prev_l.t = lineresp_type;
            prev_l.d = lineresp_data;
            prev_lval = lineresp_val;
        end
    end

    // Issues a line request and records what the line-level model predicts.
    task automatic send_line(input logic [3:0] t, input logic [31:0] a, input logic [L-1:0] d);
        int n;
        line_t le;
        word_t we;
        logic [31:0] base;
        @(negedge clk);
        linereq_val  = 1'b1;
        linereq_type = t;
        linereq_addr = a;
        linereq_data = d;
        n = 0;
        while (!linereq_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!linereq_rdy) begin
            chk("linereq_accept", linereq_rdy, 1'b1);
            linereq_val = 1'b0;
            return;
        end
        acc_edge = cyc;
        base = a & ~32'(4 * P - 1);
        le.t = t;
        le.d = '0;
        for (int i = 0; i < P; i++) begin
            we.a = base + 32'(4 * i);
            we.t = t;
            if (t == 4'd0) begin
                we.d = 32'd0;
                le.d[32*i +: 32] = ref_mem.exists(we.a) ? ref_mem[we.a] : 32'd0;
            end else begin
                we.d = d[32*i +: 32];
                ref_mem[we.a] = we.d;
            end
            exp_word_q.push_back(we);
        end
        exp_line_q.push_back(le);
        @(negedge clk);
        linereq_val  = 1'b0;
        linereq_type = '0;
        linereq_addr = '0;
        linereq_data = '0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_line_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("line_done", exp_line_q.size(), 0);
        exp_line_q.delete();
        exp_word_q.delete();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_linereq_rdy"},   linereq_rdy,   1'b0);
        chk({tag, "_wordreq_val"},   wordreq_val,   1'b0);
        chk({tag, "_wordreq_addr"},  wordreq_addr,  32'd0);
        chk({tag, "_wordreq_data"},  wordreq_data,  32'd0);
        chk({tag, "_wordresp_rdy"},  wordresp_rdy,  1'b0);
        chk({tag, "_lineresp_val"},  lineresp_val,  1'b0);
        chk({tag, "_lineresp_data"}, lineresp_data, '0);
    endtask

    initial begin
        int n;
        logic [3:0]  t;
        logic [31:0] a;
        logic [L-1:0] d;
        reset         = 1'b0;
        linereq_val   = 1'b0;
        linereq_type  = '0;
        linereq_addr  = '0;
        linereq_data  = '0;
        lineresp_rdy  = 1'b0;
        wordreq_rdy   = 1'b0;
        wordresp_val  = 1'b0;
        wordresp_data = '0;
        wordresp_type = '0;
        for (int i = 0; i < 4; i++) begin
            mem[32'h100 + 32'(4 * i)]     = 32'hA0 + 32'(i);
            ref_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        end

        repeat (2) @(negedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        #3 reset = 1'b1;
        #1 chk("release_linereq_rdy", linereq_rdy, 1'b1);

        // Read with 1-cycle memory; expected {A3,A2,A1,A0}.
        delay_mode = 1;
        lat_expect = P + 2;
        send_line(4'd0, 32'h104, '0);
        wait_done();

        // Write line then read it back.
        send_line(4'd1, 32'h200, {32'h44, 32'h33, 32'h22, 32'h11});
        wait_done();
        send_line(4'd0, 32'h200, '0);
        wait_done();

        // Unaligned address maps onto its line base.
        lat_expect = 0;
        send_line(4'd1, 32'h300, {$urandom, $urandom, $urandom, $urandom});
        wait_done();
        send_line(4'd0, 32'h30F, '0);
        wait_done();

        // Zero-latency memory: request and response fire on the same edge.
        delay_mode = 0;
        lat_expect = P + 1;
        send_line(4'd0, 32'h200, '0);
        wait_done();
        send_line(4'd7, 32'h208, {$urandom, $urandom, $urandom, $urandom});
        wait_done();
        send_line(4'd0, 32'h200, '0);
        wait_done();

        // Random stalls on both sides, random memory delay, random traffic.
        delay_mode = -1;
        rand_wrdy  = 1'b1;
        lat_expect = 0;
        for (int k = 0; k < 24; k++) begin
            t = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            a = 32'h1000 + (32'($urandom_range(0, 7)) << 4) + 32'($urandom_range(0, 15));
            d = {$urandom, $urandom, $urandom, $urandom};
            stall_left = 3;
            send_line(t, a, d);
            wait_done();
        end

        // Asynchronous reset in the middle of BUSY.
        delay_mode = 5;
        rand_wrdy  = 1'b0;
        stall_left = 0;
        word_total = 0;
        send_line(4'd0, 32'h100, '0);
        n = 0;
        while (word_total < 2 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk("midop_two_requests", 32'(word_total >= 2), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("midop_reset");
        exp_line_q.delete();
        exp_word_q.delete();
        words_this_line = 0;
        repeat (2) @(negedge clk);
        #3 reset = 1'b1;
        #1 chk("midop_release_rdy", linereq_rdy, 1'b1);
        delay_mode = 1;
        lat_expect = P + 2;
        send_line(4'd0, 32'h100, '0);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
